// File: rtl/reg_mask_encoder_pkg.sv
// Shared constants, FSM encoding and a lowest-set-bit helper for the
// register-mask encoder and other register-file blocks.
package reg_mask_encoder_pkg;

    localparam int N_REGS = 32;
    localparam int IDX_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REGS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[IDX_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_mask_encoder_lsb_priority_enc.sv
// Combinational lowest-set-bit priority encoder.
module lsb_priority_enc #(
    parameter int N_REGS = 32,
    parameter int IDX_W  = 5
) (
    input  logic [N_REGS-1:0] vec,
    output logic [IDX_W-1:0]  index,
    output logic              any_set
);

    always_comb begin
        index = '0;
        // Scan high to low so the lowest set bit is written last and wins.
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (vec[i]) index = i[IDX_W-1:0];
        end
        any_set = |vec;
    end

endmodule

// File: rtl/reg_mask_encoder.sv
// Sequential 32-to-5 encoder: emits the index of every set bit of a loaded
// register mask, lowest first, one per valid/ready handshake.
module reg_mask_encoder
    import reg_mask_encoder_pkg::*;
#(
    parameter int N_REGS = reg_mask_encoder_pkg::N_REGS,
    parameter int IDX_W  = reg_mask_encoder_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [N_REGS-1:0] mask_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_index,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    emit_count
);

    state_t            state, state_next;
    logic [N_REGS-1:0] pending, pending_next;
    logic [N_REGS-1:0] remaining;
    logic [IDX_W-1:0]  lsb_index;
    logic [IDX_W-1:0]  last_index;
    logic [IDX_W:0]    count_next;
    logic [IDX_W-1:0]  last_next;
    logic              lsb_any;
    logic              xfer;
    logic              done_next;

    lsb_priority_enc #(
        .N_REGS (N_REGS),
        .IDX_W  (IDX_W)
    ) u_enc (
        .vec     (pending),
        .index   (lsb_index),
        .any_set (lsb_any)
    );

    assign out_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    // Outside EMIT the last transferred index is held on the port.
    assign out_index = (state == EMIT) ? lsb_index : last_index;
    assign xfer      = out_valid && out_ready;
    // x & (x-1) clears the lowest set bit, i.e. the one being emitted.
    assign remaining = pending & (pending - {{(N_REGS-1){1'b0}}, 1'b1});

    always_comb begin
        state_next   = state;
        pending_next = pending;
        count_next   = emit_count;
        last_next    = last_index;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    count_next = '0;
                    if (mask_in != '0) begin
                        pending_next = mask_in;
                        state_next   = EMIT;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    pending_next = remaining;
                    count_next   = emit_count + {{IDX_W{1'b0}}, 1'b1};
                    last_next    = lsb_index;
                    if (remaining == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                // Defensive: an empty pending set cannot be emitted from.
                if (!lsb_any) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            emit_count <= '0;
            last_index <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            emit_count <= count_next;
            last_index <= last_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Randomised self-checking bench for reg_mask_encoder against a queue model.
module tb_reg_mask_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] mask_in;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  out_index;
    logic        busy;
    logic        done;
    logic [5:0]  emit_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of indices still to emit.
    int q[$];
    int m_last = 0;
    int m_cnt = 0;
    bit m_done = 0;
    int log_q[$];

    reg_mask_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .mask_in    (mask_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done),
        .emit_count (emit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [31:0] m, input logic rdy);
        bit nd;
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
        chk("out_index", {27'd0, out_index}, (q.size() != 0) ? q[0] : m_last);
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("emit_count", {26'd0, emit_count}, m_cnt);
        if (out_valid && rdy && !rst) log_q.push_back(int'(out_index));
        reset = rst; load = ld; mask_in = m; out_ready = rdy;
        nd = 0;
        if (rst) begin
            q.delete(); m_cnt = 0; m_last = 0;
        end else if (q.size() == 0) begin
            if (ld) begin
                m_cnt = 0;
                for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
                if (q.size() == 0) nd = 1;
            end
        end else if (rdy) begin
            m_last = q.pop_front();
            m_cnt++;
            if (q.size() == 0) nd = 1;
        end
        m_done = nd;
    endtask

    // Load a mask, then drain with optional random ready and stray loads.
    task automatic run_mask(input logic [31:0] m, input bit rand_rdy, input bit stray);
        int n = 0;
        step(0, 1, m, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        while (q.size() != 0 && n < 400) begin
            step(0, stray ? 1'($urandom_range(0, 1)) : 1'b0, $urandom,
                 rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
        step(0, 0, 0, 1);
    endtask

    task automatic chk_log(input string tag, input int exp[$]);
        chk({tag, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk({tag, "_idx"}, log_q[i], exp[i]);
    endtask

    initial begin
        int exp_l[$];
        logic [31:0] rm;
        reset = 1; load = 0; mask_in = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        reset = 0;

        // 0x29 -> 0,3,5
        log_q.delete();
        run_mask(32'h0000_0029, 0, 0);
        exp_l = '{0, 3, 5};
        chk_log("m29", exp_l);
        chk("m29_count", {26'd0, emit_count}, 32'd3);

        // Stall then 31
        log_q.delete();
        step(0, 1, 32'h8000_0001, 0);
        repeat (4) step(0, 0, 0, 0);
        while (q.size() != 0) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        exp_l = '{0, 31};
        chk_log("stall", exp_l);

        // All ones
        log_q.delete();
        run_mask(32'hFFFF_FFFF, 0, 0);
        exp_l.delete();
        for (int i = 0; i < 32; i++) exp_l.push_back(i);
        chk_log("ones", exp_l);
        chk("ones_count", {26'd0, emit_count}, 32'd32);

        // Zero mask
        step(0, 1, 32'h0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Bit 31 only, with a load arriving in the done cycle
        log_q.delete();
        step(0, 1, 32'h8000_0000, 1);
        step(0, 0, 0, 1);
        step(0, 1, 32'h0000_0006, 1);
        while (q.size() != 0) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        exp_l = '{31, 1, 2};
        chk_log("b31", exp_l);

        // Load ignored in EMIT, reset after 2nd transfer
        log_q.delete();
        step(0, 1, 32'h0000_00F0, 1);
        step(0, 1, 32'h0000_0001, 1);
        step(0, 1, 32'h0000_0001, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        exp_l = '{4, 5};
        chk_log("rst", exp_l);

        // Random ready on 0xA5A5_0000
        log_q.delete();
        run_mask(32'hA5A5_0000, 1, 1);
        exp_l = '{16, 18, 21, 23, 24, 26, 29, 31};
        chk_log("a5", exp_l);

        // Random masks, ready and stray loads
        for (int t = 0; t < 40; t++) begin
            rm = (t % 3 == 0) ? ($urandom & $urandom & $urandom) : $urandom;
            if (t % 7 == 0) rm = 32'h0;
            log_q.delete();
            run_mask(rm, 1, 1);
            exp_l.delete();
            for (int i = 0; i < 32; i++) if (rm[i]) exp_l.push_back(i);
            chk_log("rnd", exp_l);
            if (t % 9 == 4) begin
                step(0, 1, $urandom | 32'h1, 1);
                step(0, 0, 0, 1);
                step(1, 0, 0, 0);
                step(0, 0, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
